// File: rtl/conv_enc_k3.sv
// Rate-1/2, K=3 convolutional encoder with a valid/ready handshake on both sides.
// Define CONV_ENC_TERM_EN to append two zero tail bits per frame; otherwise frames are truncated.
module conv_enc_k3 #(
    parameter logic [2:0] G0 = 3'b111,
    parameter logic [2:0] G1 = 3'b101
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    typedef enum logic [1:0] {StRun, StTail0, StTail1} state_e;

    state_e     state_q, state_d;
    logic [1:0] sr_q, sr_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_sym_q, out_sym_d;
    logic       out_last_q, out_last_d;
    logic       busy_q, busy_d;

    logic       slot_free;
    logic       accept;
    logic       tail_load;
    logic       last_sym;
    logic       clr_sr;
    logic       load;
    logic       u;
    logic [2:0] taps;
    logic [1:0] sym;

    always_comb begin
        state_d   = state_q;
        tail_load = 1'b0;
        last_sym  = 1'b0;
        clr_sr    = 1'b0;

        slot_free = !out_valid_q || out_ready;
        in_ready  = (state_q == StRun) && slot_free;
        accept    = in_valid && in_ready;

`ifdef CONV_ENC_TERM_EN
        unique case (state_q)
            StRun: begin
                if (accept && in_last) state_d = StTail0;
            end
            StTail0: begin
                if (slot_free) begin
                    tail_load = 1'b1;
                    state_d   = StTail1;
                end
            end
            StTail1: begin
                if (slot_free) begin
                    tail_load = 1'b1;
                    last_sym  = 1'b1;
                    state_d   = StRun;
                end
            end
            default: state_d = StRun;
        endcase
`else
        // Truncated frames: the last data symbol closes the frame and the trellis restarts at 0.
        state_d  = StRun;
        last_sym = accept && in_last;
        clr_sr   = accept && in_last;
`endif

        // Tail steps encode u = 0, which also drains sr back to 2'b00.
        u    = accept ? in_bit : 1'b0;
        load = accept || tail_load;
        taps = {u, sr_q[0], sr_q[1]};
        sym  = {^(G0 & taps), ^(G1 & taps)};

        sr_d        = sr_q;
        out_valid_d = out_valid_q;
        out_sym_d   = out_sym_q;
        out_last_d  = out_last_q;

        if (slot_free) out_valid_d = load;
        if (load) begin
            out_sym_d  = sym;
            out_last_d = last_sym;
            sr_d       = clr_sr ? 2'b00 : {sr_q[0], u};
        end

        // A new frame accepted on the edge that retires out_last keeps busy high.
        busy_d = busy_q;
        if (out_valid_q && out_ready && out_last_q) busy_d = 1'b0;
        if (accept) busy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            sr_q        <= 2'b00;
            out_valid_q <= 1'b0;
            out_sym_q   <= 2'b00;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            out_valid_q <= out_valid_d;
            out_sym_q   <= out_sym_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sym   = out_sym_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;

endmodule
